// File: rtl/banco_registradores.sv
// banco_registradores: 32x32-bit MIPS register file with $zero hardwired to 0,
// $sp reset to SP_RESET, and optional same-cycle write-to-read bypass.
module banco_registradores #(
   parameter logic [31:0] SP_RESET = 32'd227,
   parameter int          BYPASS   = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWrite,
   input  logic [4:0]  ReadReg1,
   input  logic [4:0]  ReadReg2,
   input  logic [4:0]  WriteReg,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2
);
   logic [31:0] r_regs [0:31];
   logic        w_we;
   logic        w_byp1;
   logic        w_byp2;
   assign w_we   = RegWrite && !reset && (WriteReg != 5'd0);
   assign w_byp1 = (BYPASS != 0) && w_we && (WriteReg == ReadReg1);
   assign w_byp2 = (BYPASS != 0) && w_we && (WriteReg == ReadReg2);
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < 32; i++) r_regs[i] <= (i == 29) ? SP_RESET : 32'd0;
      else if (w_we)
         r_regs[WriteReg] <= WriteData;
   // Index 0 is forced to zero on read so r0 can never leak a value.
   assign ReadData1 = (ReadReg1 == 5'd0) ? 32'd0 : w_byp1 ? WriteData : r_regs[ReadReg1];
   assign ReadData2 = (ReadReg2 == 5'd0) ? 32'd0 : w_byp2 ? WriteData : r_regs[ReadReg2];
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: scoreboard bench driving a bypassing and a
// non-bypassing register file with the same directed vectors.
module tb_banco_registradores;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        RegWrite = 1'b0;
   logic [4:0]  ReadReg1 = 5'd0;
   logic [4:0]  ReadReg2 = 5'd0;
   logic [4:0]  WriteReg = 5'd0;
   logic [31:0] WriteData = 32'd0;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      string       name;
      logic [31:0] b1, b2, n1, n2;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   banco_registradores #(.SP_RESET(32'd227), .BYPASS(1)) u_byp (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
      .WriteData(WriteData), .ReadData1(rd1_b), .ReadData2(rd2_b));

   banco_registradores #(.SP_RESET(32'd227), .BYPASS(0)) u_nob (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
      .WriteData(WriteData), .ReadData1(rd1_n), .ReadData2(rd2_n));

   task automatic cmp(input string n, input string port, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", n, port, act, exp);
      end
   endtask

   // Monitor: pops expectations and compares against the live outputs.
   initial begin
      exp_t e;
      forever begin
         wait (sb.size() > 0);
         e = sb.pop_front();
         cmp(e.name, "byp.rd1", rd1_b, e.b1);
         cmp(e.name, "byp.rd2", rd2_b, e.b2);
         cmp(e.name, "nob.rd1", rd1_n, e.n1);
         cmp(e.name, "nob.rd2", rd2_n, e.n2);
      end
   end

   task automatic expect_rd(input string n, input logic [31:0] b1, input logic [31:0] b2,
                            input logic [31:0] n1, input logic [31:0] n2);
      exp_t e;
      #1;
      e.name = n; e.b1 = b1; e.b2 = b2; e.n1 = n1; e.n2 = n2;
      sb.push_back(e);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
      RegWrite = we; WriteReg = wr; WriteData = wd; ReadReg1 = r1; ReadReg2 = r2;
   endtask

   initial begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
      expect_rd("reset_init", 227, 0, 227, 0);
      reset = 1'b0;
      // basic write
      @(negedge clk);
      drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd9);
      expect_rd("basic", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
      // $zero protection
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      expect_rd("zero_pre", 0, 0, 0, 0);
      @(negedge clk);
      RegWrite = 1'b0;
      expect_rd("zero_post", 0, 0, 0, 0);
      // write-address mux destinations
      drive(1'b1, 5'd31, 32'h40, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b1, 5'd29, 32'd200, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd29);
      expect_rd("ra_sp", 32'h40, 200, 32'h40, 200);
      drive(1'b0, 5'd31, 32'h123, 5'd31, 5'd29);
      @(negedge clk);
      expect_rd("we_low", 32'h40, 200, 32'h40, 200);
      // bypass
      drive(1'b1, 5'd10, 32'd5, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b1, 5'd10, 32'd7, 5'd10, 5'd10);
      expect_rd("byp_pre", 7, 7, 5, 5);
      @(negedge clk);
      expect_rd("byp_post", 7, 7, 7, 7);
      drive(1'b1, 5'd10, 32'd9, 5'd10, 5'd8);
      expect_rd("byp_indep", 9, 32'hDEADBEEF, 7, 32'hDEADBEEF);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd8);
      expect_rd("byp_indep_post", 9, 32'hDEADBEEF, 9, 32'hDEADBEEF);
      // back-to-back writes to the same index
      drive(1'b1, 5'd12, 32'd1, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b1, 5'd12, 32'd2, 5'd12, 5'd0);
      expect_rd("b2b_mid", 2, 0, 1, 0);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
      expect_rd("b2b_last", 2, 0, 2, 0);
      // reset asserted between edges
      drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
      @(negedge clk);
      #2 reset = 1'b1;
      expect_rd("rst_mid", 227, 0, 227, 0);
      for (int i = 0; i < 32; i++) begin
         ReadReg1 = 5'(i);
         ReadReg2 = 5'(31 - i);
         expect_rd("rst_sweep", (i == 29) ? 32'd227 : 32'd0, (i == 2) ? 32'd227 : 32'd0,
                   (i == 29) ? 32'd227 : 32'd0, (i == 2) ? 32'd227 : 32'd0);
      end
      // reset versus write
      @(negedge clk);
      drive(1'b1, 5'd29, 32'd1, 5'd29, 5'd8);
      expect_rd("rst_vs_wr_pre", 227, 0, 227, 0);
      @(negedge clk);
      expect_rd("rst_vs_wr_post", 227, 0, 227, 0);
      reset = 1'b0;
      expect_rd("rst_rel_byp", 1, 0, 227, 0);
      @(negedge clk);
      RegWrite = 1'b0;
      expect_rd("rst_rel_wr", 1, 0, 1, 0);
      for (int k = 0; k < 100 && sb.size() > 0; k++) #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
